updown_counter_param: RTL and testbench

- Parametrised up/down counter; next generation of the 4-bit dual-output counter driven from the PLL-derived clock.
- Adds:
  - configurable width and modulus
  - built-in clock-enable prescaler
  - wrap or saturate mode
  - synchronous clear and load
  - terminal-count and boundary flags
- Sits behind the clock/reset generation in the top counter, driving display/LED logic directly.

---
 rtl/updown_counter_param_pkg.sv | 28 ++
 rtl/updown_counter_param_tick_prescaler.sv | 56 +++++
 rtl/updown_counter_param.sv | 120 ++++++++++++
 tb/tb_updown_counter_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_param_pkg.sv
// Shared definitions for the parametrised up/down counter: direction encodings
// and the constant functions used to size internal registers.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 32'd0;
        rem    = (value > 32'd0) ? (value - 32'd1) : 32'd0;
        while (rem > 32'd0) begin
            result = result + 32'd1;
            rem    = rem >> 32'd1;
        end
        return result;
    endfunction

    // Prescaler register width; never narrower than one bit.
    function automatic int unsigned presc_width(input int unsigned prescale);
        int unsigned w;
        w = clog2(prescale);
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/updown_counter_param_tick_prescaler.sv
// Clock-enable prescaler: raises tick once every PRESCALE enabled cycles and
// can be restarted to phase zero by a clear or load in the parent.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic refclk,
    input  logic reset_count_n,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int unsigned   PW        = presc_width(int'(PRESCALE));
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 32'sd1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(32'd1);
    localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};

    generate
        if (PRESCALE < 32'sd1) begin : g_bad_prescale
            $error("tick_prescaler: PRESCALE must be at least 1");
        end
    endgenerate

    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nxt_s;
    logic          tick_s;

    assign tick_s = enable && (presc_r == PRESC_MAX);
    assign tick   = tick_s;

    // Next prescale phase: restart wins, a tick wraps to zero, enable advances.
    always_comb begin
        presc_nxt_s = presc_r;
        if (restart) begin
            presc_nxt_s = PRESC_ZERO;
        end else if (tick_s) begin
            presc_nxt_s = PRESC_ZERO;
        end else if (enable) begin
            presc_nxt_s = presc_r + PRESC_ONE;
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // Prescale phase register.
    always_ff @(posedge refclk or negedge reset_count_n) begin
        if (!reset_count_n) begin
            presc_r <= PRESC_ZERO;
        end else begin
            presc_r <= presc_nxt_s;
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with prescaled stepping, wrap or saturate at the
// range ends, synchronous clear/load and terminal-count / boundary flags.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             refclk,
    input  logic             reset_count_n,
    input  logic             enable,
    input  logic             counter_direction,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             terminal_count,
    output logic             boundary_pulse
);

    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULUS - 32'sd1);
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(32'd1);
    localparam logic             SAT_MODE = (SATURATE != 32'sd0);

    generate
        if ((MODULUS < 32'sd2) || (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_bad_modulus
            $error("updown_counter_param: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
        if (PRESCALE < 32'sd1) begin : g_bad_prescale
            $error("updown_counter_param: PRESCALE must be at least 1");
        end
        if ((SATURATE != 32'sd0) && (SATURATE != 32'sd1)) begin : g_bad_saturate
            $error("updown_counter_param: SATURATE must be 0 or 1");
        end
    endgenerate

    logic             tick_s;
    logic             restart_s;
    logic             at_max_s;
    logic             at_zero_s;
    logic [WIDTH-1:0] load_clamped_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             step_r;
    logic             step_nxt_s;
    logic             bpulse_r;
    logic             bpulse_nxt_s;

    // A clear or load re-aligns the prescale phase so the next step is a full period away.
    assign restart_s = clear | load;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .refclk        (refclk),
        .reset_count_n (reset_count_n),
        .enable        (enable),
        .restart       (restart_s),
        .tick          (tick_s)
    );

    assign at_max_s       = (count_r == CNT_MAX);
    assign at_zero_s      = (count_r == CNT_ZERO);
    assign load_clamped_s = (load_value > CNT_MAX) ? CNT_MAX : load_value;

    // Next count and flag values; clear beats load, load beats a coincident step.
    always_comb begin
        count_nxt_s  = count_r;
        step_nxt_s   = 1'b0;
        bpulse_nxt_s = 1'b0;
        if (clear) begin
            count_nxt_s = CNT_ZERO;
        end else if (load) begin
            count_nxt_s = load_clamped_s;
        end else if (tick_s) begin
            step_nxt_s = 1'b1;
            if (counter_direction == DIR_UP) begin
                if (at_max_s) begin
                    bpulse_nxt_s = 1'b1;
                    count_nxt_s  = SAT_MODE ? CNT_MAX : CNT_ZERO;
                end else begin
                    count_nxt_s  = count_r + CNT_ONE;
                end
            end else begin
                if (at_zero_s) begin
                    bpulse_nxt_s = 1'b1;
                    count_nxt_s  = SAT_MODE ? CNT_ZERO : CNT_MAX;
                end else begin
                    count_nxt_s  = count_r - CNT_ONE;
                end
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count and flag registers.
    always_ff @(posedge refclk or negedge reset_count_n) begin
        if (!reset_count_n) begin
            count_r  <= CNT_ZERO;
            step_r   <= 1'b0;
            bpulse_r <= 1'b0;
        end else begin
            count_r  <= count_nxt_s;
            step_r   <= step_nxt_s;
            bpulse_r <= bpulse_nxt_s;
        end
    end

    assign count          = count_r;
    assign step           = step_r;
    assign boundary_pulse = bpulse_r;
    assign terminal_count = (at_max_s  && (counter_direction == DIR_UP)) ||
                            (at_zero_s && (counter_direction == DIR_DOWN));

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: a wrap instance and a saturate instance share
// stimulus and are compared every cycle against an arithmetic reference model.
module tb_updown_counter_param;

    localparam int W  = 4;
    localparam int M  = 10;
    localparam int P  = 3;

    logic         refclk = 1'b0;
    logic         reset_count_n;
    logic         enable;
    logic         counter_direction;
    logic         clear;
    logic         load;
    logic [W-1:0] load_value;

    logic [W-1:0] cnt_w, cnt_s;
    logic         step_w, step_s, tc_w, tc_s, bp_w, bp_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 refclk = ~refclk;

    updown_counter_param #(.WIDTH(W), .MODULUS(M), .PRESCALE(P), .SATURATE(0)) dut_wrap (
        .refclk(refclk), .reset_count_n(reset_count_n), .enable(enable),
        .counter_direction(counter_direction), .clear(clear), .load(load),
        .load_value(load_value), .count(cnt_w), .step(step_w),
        .terminal_count(tc_w), .boundary_pulse(bp_w));

    updown_counter_param #(.WIDTH(W), .MODULUS(M), .PRESCALE(P), .SATURATE(1)) dut_sat (
        .refclk(refclk), .reset_count_n(reset_count_n), .enable(enable),
        .counter_direction(counter_direction), .clear(clear), .load(load),
        .load_value(load_value), .count(cnt_s), .step(step_s),
        .terminal_count(tc_s), .boundary_pulse(bp_s));

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Reference model: index 0 wraps, index 1 saturates.
    int m_enabled;
    int m_cnt  [2];
    int m_step [2];
    int m_bp   [2];

    always @(posedge refclk or negedge reset_count_n) begin
        if (!reset_count_n) begin
            m_enabled = 0;
            for (int s = 0; s < 2; s++) begin
                m_cnt[s] = 0; m_step[s] = 0; m_bp[s] = 0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                m_step[s] = 0; m_bp[s] = 0;
            end
            if (clear) begin
                m_enabled = 0;
                m_cnt[0] = 0; m_cnt[1] = 0;
            end else if (load) begin
                m_enabled = 0;
                m_cnt[0] = (int'(load_value) > M - 1) ? M - 1 : int'(load_value);
                m_cnt[1] = m_cnt[0];
            end else if (enable) begin
                m_enabled = m_enabled + 1;
                if (m_enabled == P) begin
                    m_enabled = 0;
                    for (int s = 0; s < 2; s++) begin
                        int t;
                        t = counter_direction ? m_cnt[s] + 1 : m_cnt[s] - 1;
                        m_step[s] = 1;
                        if (t < 0 || t >= M) begin
                            m_bp[s] = 1;
                            t = (s == 1) ? m_cnt[s] : (t + M) % M;
                        end
                        m_cnt[s] = t;
                    end
                end
            end
        end
    end

    function automatic int model_tc(input int c, input logic up);
        return ((c == M - 1) && up) || ((c == 0) && !up) ? 1 : 0;
    endfunction

    // Cycle-by-cycle comparison, sampled well after the rising edge.
    initial begin
        forever begin
            @(posedge refclk);
            #3;
            check("count_wrap", int'(cnt_w),  m_cnt[0]);
            check("step_wrap",  int'(step_w), m_step[0]);
            check("bp_wrap",    int'(bp_w),   m_bp[0]);
            check("tc_wrap",    int'(tc_w),   model_tc(m_cnt[0], counter_direction));
            check("count_sat",  int'(cnt_s),  m_cnt[1]);
            check("step_sat",   int'(step_s), m_step[1]);
            check("bp_sat",     int'(bp_s),   m_bp[1]);
            check("tc_sat",     int'(tc_s),   model_tc(m_cnt[1], counter_direction));
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge refclk);
    endtask

    initial begin
        reset_count_n = 1'b1; enable = 1'b0; counter_direction = 1'b1;
        clear = 1'b0; load = 1'b0; load_value = 4'd0;
        #1 reset_count_n = 1'b0;
        tick_n(2);
        check("rst_count", int'(cnt_w), 0);
        check("rst_step",  int'(step_w), 0);
        check("rst_bp",    int'(bp_w), 0);
        check("rst_count_sat", int'(cnt_s), 0);
        reset_count_n = 1'b1;

        // Up wrap from 8
        load = 1'b1; load_value = 4'd8; counter_direction = 1'b1;
        tick_n(1);
        check("load8", int'(cnt_w), 8);
        load = 1'b0; enable = 1'b1;
        tick_n(2);
        check("hold8", int'(cnt_w), 8);
        tick_n(1);
        check("up_to9", int'(cnt_w), 9);
        check("up_to9_step", int'(step_w), 1);
        check("tc_at9", int'(tc_w), 1);
        tick_n(3);
        check("wrap_to0", int'(cnt_w), 0);
        check("wrap_bp", int'(bp_w), 1);
        check("sat_hold9", int'(cnt_s), 9);
        check("sat_bp", int'(bp_s), 1);
        tick_n(1);
        check("bp_one_cycle", int'(bp_w), 0);

        // Down wrap from 1
        load = 1'b1; load_value = 4'd1; counter_direction = 1'b0;
        tick_n(1);
        load = 1'b0;
        check("load1", int'(cnt_w), 1);
        tick_n(3);
        check("down_to0", int'(cnt_w), 0);
        check("down_to0_bp", int'(bp_w), 0);
        check("tc_at0_down", int'(tc_w), 1);
        tick_n(3);
        check("down_wrap9", int'(cnt_w), 9);
        check("down_wrap_bp", int'(bp_w), 1);
        check("sat_hold0", int'(cnt_s), 0);
        check("sat_hold0_bp", int'(bp_s), 1);

        // Saturate at 9 for nine cycles
        load = 1'b1; load_value = 4'd9; counter_direction = 1'b1;
        tick_n(1);
        load = 1'b0;
        tick_n(3);
        check("sat_c3_cnt", int'(cnt_s), 9);
        check("sat_c3_step", int'(step_s), 1);
        check("sat_c3_bp", int'(bp_s), 1);
        tick_n(1);
        check("sat_c4_step", int'(step_s), 0);
        tick_n(2);
        check("sat_c6_bp", int'(bp_s), 1);
        tick_n(3);
        check("sat_c9_cnt", int'(cnt_s), 9);
        check("sat_c9_bp", int'(bp_s), 1);
        check("wrap_c9_cnt", int'(cnt_w), 2);

        // Clamp and priority
        load = 1'b1; load_value = 4'd12;
        tick_n(1);
        check("clamp12", int'(cnt_w), 9);
        clear = 1'b1; load_value = 4'd5;
        tick_n(1);
        check("clear_over_load", int'(cnt_w), 0);
        clear = 1'b0; load = 1'b0;
        tick_n(2);
        check("pre_load_step", int'(cnt_w), 0);
        load = 1'b1; load_value = 4'd3;
        tick_n(1);
        check("load_beats_step", int'(cnt_w), 3);
        check("load_no_step", int'(step_w), 0);
        load = 1'b0;
        tick_n(2);
        check("restart_hold", int'(cnt_w), 3);
        tick_n(1);
        check("restart_step", int'(cnt_w), 4);

        // Enable gating
        tick_n(2);
        enable = 1'b0;
        tick_n(5);
        check("gap_hold", int'(cnt_w), 4);
        enable = 1'b1;
        tick_n(1);
        check("reenable_step", int'(cnt_w), 5);
        check("reenable_step_flag", int'(step_w), 1);

        // Asynchronous reset mid-count
        enable = 1'b0; load = 1'b1; load_value = 4'd6;
        tick_n(1);
        load = 1'b0;
        check("load6", int'(cnt_w), 6);
        #1 reset_count_n = 1'b0;
        #1;
        check("async_rst_cnt", int'(cnt_w), 0);
        check("async_rst_step", int'(step_w), 0);
        check("async_rst_bp", int'(bp_w), 0);
        check("async_rst_cnt_sat", int'(cnt_s), 0);
        enable = 1'b1; counter_direction = 1'b1;
        #1 reset_count_n = 1'b1;
        tick_n(2);
        check("post_rst_hold", int'(cnt_w), 0);
        tick_n(1);
        check("post_rst_first", int'(cnt_w), 1);

        tick_n(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
